// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Combinational helpers only; no latency.
// No flow control of its own.
package lsu_pkg;

  // funct3 encodings for the supported access sizes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

  // True for the five funct3 codes the unit knows how to perform
  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
      default:                        f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge port of the load/store unit.
// Wires only; no latency.
// Request is held by the master until the slave raises mem_ack.
interface mem_stage_lsu_if #(parameter int DATA_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replication, load extraction/extension, alignment check.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic [15:0] lane;

  // Select lanes by size; illegal funct3 leaves everything benign (the top rejects it)
  always_comb begin
    lane       = 16'(rdata >> {off, 3'b000});
    be         = 4'b0000;
    wdata_rep  = wdata;
    load_ext   = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        load_ext  = (funct3 == F3_B) ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << off;
        wdata_rep  = {2{wdata[15:0]}};
        load_ext   = (funct3 == F3_H) ? {{16{lane[15]}}, lane} : {16'b0, lane};
        misaligned = off[0];
      end
      F3_W: begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        load_ext   = rdata;
        misaligned = (off != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: single-outstanding memory access with watchdog fault.
// Access in cycle 0 -> mem_req from cycle 1; ack in cycle k -> result and stall release in cycle k+1.
// Stalls the pipeline while in flight; memory backpressures by withholding mem_ack (up to TIMEOUT cycles).
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,   // lane logic is 4 bytes wide, so only 32 works
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mRead,
  input  logic              mWrite,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  mem_stage_lsu_if.master   mem,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              fault_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t        state;
  logic [CNT_W-1:0]  wd_cnt;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] load_ext;
  logic              misaligned;
  logic              access;
  logic              legal;
  logic              start;
  logic              bad;

  lsu_align u_align (
    .funct3    (funct3),
    .off       (addr[1:0]),
    .wdata     (wdata),
    .rdata     (mem.mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .load_ext  (load_ext),
    .misaligned(misaligned)
  );

  // Decode the instruction sitting in MEM
  always_comb begin
    access = mRead ^ mWrite;
    legal  = f3_legal(funct3);
    start  = access & legal & ~misaligned;
    bad    = (mRead & mWrite) | (access & (~legal | misaligned));
  end

  // Stall from the first cycle of a good access until DONE; never during reset
  always_comb begin
    stall_o = ~rst & (((state == IDLE) & start) | (state == BUSY));
  end

  // Access FSM with registered memory port, result, fault pulse and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wd_cnt        <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= 4'b0000;
      mem.mem_wdata <= '0;
      load_data_o   <= '0;
      fault_o       <= 1'b0;
    end else begin
      fault_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= mWrite;
            mem.mem_addr  <= {addr[DATA_W-1:2], 2'b00};
            mem.mem_be    <= be;
            mem.mem_wdata <= wdata_rep;
            wd_cnt        <= '0;
            state         <= BUSY;
          end else if (bad) begin
            fault_o <= 1'b1;
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_we) load_data_o <= load_ext;
            state <= DONE;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            mem.mem_req <= 1'b0;
            fault_o     <= 1'b1;
            load_data_o <= '0;
            state       <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        // The finished instruction is still on the inputs here; do not re-issue it
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
